sha_dbl_hash_ctrl: RTL

// - Initiator side of the sha_block interface in the bitcoin miner.
// - Accepts an 80-byte block header and builds the padded 512-bit message blocks.
// - Drives sha_block en/M/H_prev and chains midstates across three passes:
//   hdr[0:63] -> hdr[64:79]+pad -> digest+pad. This yields SHA256(SHA256(hdr)).
// - Reports the final hash and a target hit flag to the nonce/job logic.

---
 rtl/sha_pkg.sv | 55 +++++
 rtl/sha_pad_mux.sv | 35 +++
 rtl/sha_dbl_hash_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 constants and controller state encoding for the
// double-hash initiator and other sha_block users.
package sha_pkg;

    localparam int HDR_BITS = 640;
    localparam int BLK_BITS = 512;
    localparam int DIG_BITS = 256;

    // Padding: a single 1 bit (0x80 byte), zero fill, 64-bit message length.
    localparam logic [7:0]  PAD_BYTE = 8'h80;
    localparam int          HDR_ZPAD = 312;   // 128 + 8 + 312 + 64 = 512
    localparam int          DIG_ZPAD = 184;   // 256 + 8 + 184 + 64 = 512
    localparam logic [63:0] HDR_LEN  = 64'd640;
    localparam logic [63:0] DIG_LEN  = 64'd256;

    localparam logic [DIG_BITS-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constants, kept here so every sha_block user sees one copy.
    localparam logic [31:0] SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE, B1_ISSUE, B1_WAIT, B2_ISSUE, B2_WAIT, B3_ISSUE, B3_WAIT, DONE
    } state_t;

    // Reverse byte order of a 256-bit word (digest bytes -> little-endian number).
    function automatic logic [DIG_BITS-1:0] bswap256(input logic [DIG_BITS-1:0] v);
        logic [DIG_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[DIG_BITS-1-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha_pad_mux.sv
// Combinational message-block builder: selects M and H_prev for the pass
// about to be issued. 'chain' is the sha_block result that feeds the next
// pass (midstate for pass 2, first digest for pass 3).
module sha_pad_mux
    import sha_pkg::*;
(
    input  state_t              blk,
    input  logic [HDR_BITS-1:0] hdr,
    input  logic [DIG_BITS-1:0] chain,
    output logic [BLK_BITS-1:0] m,
    output logic [DIG_BITS-1:0] h_prev
);

    // Build the padded block for the requested issue state.
    always_comb begin
        m      = '0;
        h_prev = '0;
        case (blk)
            B1_ISSUE: begin
                m      = hdr[HDR_BITS-1:128];
                h_prev = SHA256_IV;
            end
            B2_ISSUE: begin
                m      = {hdr[127:0], PAD_BYTE, {HDR_ZPAD{1'b0}}, HDR_LEN};
                h_prev = chain;
            end
            B3_ISSUE: begin
                m      = {chain, PAD_BYTE, {DIG_ZPAD{1'b0}}, DIG_LEN};
                h_prev = SHA256_IV;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sha_dbl_hash_ctrl.sv
// Double SHA-256 initiator: walks a block header through three sha_block
// passes (header block 1, header tail + pad, digest + pad), reports the
// final hash and whether it meets the difficulty target.
module sha_dbl_hash_ctrl
    import sha_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [HDR_BITS-1:0] header,
    input  logic [DIG_BITS-1:0] target,
    output logic                sha_en,
    output logic [BLK_BITS-1:0] sha_M,
    output logic [DIG_BITS-1:0] sha_H_prev,
    input  logic [DIG_BITS-1:0] sha_H,
    input  logic                sha_en_next,
    output logic                hash_valid,
    output logic [DIG_BITS-1:0] hash,
    output logic                hit,
    output logic                err
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic [HDR_BITS-1:0] hdr_q;
    logic [DIG_BITS-1:0] target_q;
    logic [CNT_W-1:0]    wd;

    state_t              blk_nxt;
    logic [HDR_BITS-1:0] hdr_src;
    logic [BLK_BITS-1:0] m_nxt;
    logic [DIG_BITS-1:0] hp_nxt;

    // Pick which block to build for the next issue. Block 1 is built straight
    // from the header port so it can be registered on the accept edge; the
    // chaining value comes straight from sha_H on the capture edge, so the
    // held sha_H_prev doubles as the midstate register.
    always_comb begin
        blk_nxt = B1_ISSUE;
        hdr_src = hdr_q;
        case (state)
            IDLE:    hdr_src = header;
            B1_WAIT: blk_nxt = B2_ISSUE;
            B2_WAIT: blk_nxt = B3_ISSUE;
            default: ;
        endcase
    end

    sha_pad_mux u_pad (
        .blk    (blk_nxt),
        .hdr    (hdr_src),
        .chain  (sha_H),
        .m      (m_nxt),
        .h_prev (hp_nxt)
    );

    // Control FSM with watchdog; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            job_ready  <= 1'b1;
            sha_en     <= 1'b0;
            sha_M      <= '0;
            sha_H_prev <= '0;
            hash_valid <= 1'b0;
            hash       <= '0;
            hit        <= 1'b0;
            err        <= 1'b0;
            wd         <= '0;
            hdr_q      <= '0;
            target_q   <= '0;
        end else begin
            sha_en     <= 1'b0;
            hash_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        hdr_q      <= header;
                        target_q   <= target;
                        sha_en     <= 1'b1;
                        sha_M      <= m_nxt;
                        sha_H_prev <= hp_nxt;
                        wd         <= '0;
                        job_ready  <= 1'b0;
                        state      <= B1_ISSUE;
                    end
                end
                B1_ISSUE: state <= B1_WAIT;
                B2_ISSUE: state <= B2_WAIT;
                B3_ISSUE: state <= B3_WAIT;
                B1_WAIT, B2_WAIT, B3_WAIT: begin
                    if (sha_en_next) begin
                        if (state == B3_WAIT) begin
                            hash       <= sha_H;
                            hit        <= (bswap256(sha_H) <= target_q);
                            hash_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            sha_en     <= 1'b1;
                            sha_M      <= m_nxt;
                            sha_H_prev <= hp_nxt;
                            wd         <= '0;
                            state      <= (state == B1_WAIT) ? B2_ISSUE : B3_ISSUE;
                        end
                    end else if (wd == WD_LAST) begin
                        // TIMEOUT wait cycles with no response: drop the job.
                        err       <= 1'b1;
                        wd        <= '0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    job_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    job_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
